// File: rtl/cus43_tile_fetch.sv
// Tilemap pixel-fetch stage: latches tile code/attribute, fetches one ROM row, shifts out pixels.
// Optional fine horizontal scroll delay line enabled by CUS43_FINE_SCROLL_EN.
module cus43_tile_fetch #(
  parameter int ROW_BITS = 3,
  parameter int GA_W     = 14
) (
  input  logic            CLK_6M,
  input  logic            RST,
  input  logic            HSYNC,
  input  logic            VSYNC,
  input  logic            FLIP,
  input  logic [7:0]      RD,
  output logic [GA_W-1:0] GROM_A,
  input  logic [15:0]     GROM_D,
  input  logic [2:0]      FINE_X,
  output logic [1:0]      PIX,
  output logic [4:0]      PAL,
  output logic            PIX_VALID
);

  logic                hs_q, hs_d, vs_q, vs_d;
  logic [2:0]          phase_q, phase_d;
  logic [ROW_BITS-1:0] row_q, row_d, row_eff;
  logic [7:0]          code_q, code_d, attr_q, attr_d;
  logic [GA_W-1:0]     ga_q, ga_d;
  logic [15:0]         pdat_q, pdat_d;
  logic [4:0]          ppal_q, ppal_d, spal_q, spal_d;
  logic [7:0]          sh1_q, sh1_d, sh0_q, sh0_d;
  logic                vsh_q, vsh_d;
  logic [1:0]          pix_q, pix_d;
  logic [4:0]          pal_q, pal_d;
  logic                vld_q, vld_d;
  logic                hfall, vfall;

  assign hfall   = hs_q & ~HSYNC;
  assign vfall   = vs_q & ~VSYNC;
  assign row_eff = FLIP ? ~row_q : row_q;
  assign GROM_A  = ga_q;

  always_comb begin
    hs_d    = HSYNC;
    vs_d    = VSYNC;
    phase_d = phase_q + 3'd1;
    row_d   = row_q;
    code_d  = code_q;
    attr_d  = attr_q;
    ga_d    = ga_q;
    pdat_d  = pdat_q;
    ppal_d  = ppal_q;
    spal_d  = spal_q;
    sh1_d   = sh1_q;
    sh0_d   = sh0_q;
    vsh_d   = vsh_q;
    pix_d   = FLIP ? {sh1_q[0], sh0_q[0]} : {sh1_q[7], sh0_q[7]};
    pal_d   = spal_q;
    vld_d   = vsh_q;

    if (vfall && hfall)  row_d = '0;
    else if (vfall)      row_d = '1;
    else if (hfall)      row_d = row_q + ROW_BITS'(1);

    if (hfall) begin
      // Line start discards the in-flight fetch and blanks the output pipe.
      phase_d = '0;
      pdat_d  = '0;
      ppal_d  = '0;
      sh1_d   = '0;
      sh0_d   = '0;
      vsh_d   = 1'b0;
      pix_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (phase_q)
        3'd0: code_d = RD;
        3'd1: attr_d = RD;
        3'd2: ga_d   = GA_W'({attr_q[2:0], code_q, row_eff});
        3'd5: begin
          pdat_d = GROM_D;
          ppal_d = attr_q[7:3];
        end
        default: ;
      endcase
      if (phase_q == 3'd7) begin
        sh1_d  = pdat_q[15:8];
        sh0_d  = pdat_q[7:0];
        spal_d = ppal_q;
        vsh_d  = 1'b1;
      end else if (FLIP) begin
        sh1_d = {1'b0, sh1_q[7:1]};
        sh0_d = {1'b0, sh0_q[7:1]};
      end else begin
        sh1_d = {sh1_q[6:0], 1'b0};
        sh0_d = {sh0_q[6:0], 1'b0};
      end
    end
  end

  always_ff @(posedge CLK_6M or posedge RST) begin
    if (RST) begin
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
      phase_q <= '0;
      row_q   <= '1;
      code_q  <= '0;
      attr_q  <= '0;
      ga_q    <= '0;
      pdat_q  <= '0;
      ppal_q  <= '0;
      spal_q  <= '0;
      sh1_q   <= '0;
      sh0_q   <= '0;
      vsh_q   <= 1'b0;
      pix_q   <= '0;
      pal_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      phase_q <= phase_d;
      row_q   <= row_d;
      code_q  <= code_d;
      attr_q  <= attr_d;
      ga_q    <= ga_d;
      pdat_q  <= pdat_d;
      ppal_q  <= ppal_d;
      spal_q  <= spal_d;
      sh1_q   <= sh1_d;
      sh0_q   <= sh0_d;
      vsh_q   <= vsh_d;
      pix_q   <= pix_d;
      pal_q   <= pal_d;
      vld_q   <= vld_d;
    end
  end

`ifdef CUS43_FINE_SCROLL_EN
  logic [2:0] fx_q;
  logic [7:0] dl_q [0:6];
  logic [7:0] tap_now;

  assign tap_now = {pix_q, pal_q, vld_q};

  // Tap 0 is the undelayed output; tap n reads entry n-1 of the line.
  always_ff @(posedge CLK_6M or posedge RST) begin
    if (RST) begin
      fx_q <= '0;
      for (int unsigned i = 0; i < 7; i++) dl_q[i] <= '0;
    end else if (hfall) begin
      fx_q <= FINE_X;
      for (int unsigned i = 0; i < 7; i++) dl_q[i] <= '0;
    end else begin
      dl_q[0] <= tap_now;
      for (int unsigned i = 1; i < 7; i++) dl_q[i] <= dl_q[i-1];
    end
  end

  assign {PIX, PAL, PIX_VALID} = (fx_q == 3'd0) ? tap_now : dl_q[fx_q - 3'd1];
`else
  logic unused_fine_x;
  assign unused_fine_x = ^FINE_X;
  assign PIX       = pix_q;
  assign PAL       = pal_q;
  assign PIX_VALID = vld_q;
`endif

endmodule
